// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - LOOK-style hall/car call scheduler with registered direction/target outputs
// Optional fire recall mode is built in when FIRE_RECALL_EN is defined.
module elevator_call_scheduler #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_button_up,
    input  logic [N-1:0] i_button_down,
    input  logic [N-1:0] i_button_select_floor,
    input  logic [N-1:0] i_floor_sensor,
    input  logic         i_serve_done,
`ifdef FIRE_RECALL_EN
    input  logic         i_fire_alert,
`endif
    output logic [N-1:0] o_cur_floor,
    output logic [N-1:0] o_pend_up,
    output logic [N-1:0] o_pend_down,
    output logic [N-1:0] o_pend_car,
    output logic [N-1:0] o_target_floor,
    output logic         o_target_valid,
    output logic         o_direction_up,
    output logic         o_direction_down,
    output logic         o_stop_here
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam logic [N-1:0] FLOOR0 = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [N-1:0] r_cur_floor;
    logic [N-1:0] r_pend_up;
    logic [N-1:0] r_pend_down;
    logic [N-1:0] r_pend_car;
    logic [N-1:0] r_target_floor;
    logic         r_target_valid;
    logic         r_direction_up;
    logic         r_direction_down;
    logic         r_stop_here;
    logic         r_fire_q;

    logic         w_fire;
    state_t       w_state_eff;
    logic         w_sensor_onehot;
    logic [N-1:0] w_cur_nxt;
    logic [N-1:0] w_cur_below_mask;
    logic [N-1:0] w_cur_above_mask;
    logic [N-1:0] w_set_any;
    logic         w_ahead_up;
    logic         w_ahead_dn;
    logic [N-1:0] w_clr_car;
    logic [N-1:0] w_clr_up;
    logic [N-1:0] w_clr_dn;
    logic [N-1:0] w_pend_up_nxt;
    logic [N-1:0] w_pend_dn_nxt;
    logic [N-1:0] w_pend_car_nxt;
    logic [N-1:0] w_any_nxt;
    logic [N-1:0] w_nxt_below_mask;
    logic [N-1:0] w_nxt_above_mask;
    logic [N-1:0] w_above_calls;
    logic [N-1:0] w_below_calls;
    logic         w_above;
    logic         w_below;
    logic         w_here_car;
    logic         w_here_up;
    logic         w_here_dn;
    state_t       w_state_nxt;
    logic         w_stop_nxt;
    logic [N-1:0] w_lowest_above;
    logic [N-1:0] w_highest_below;
    logic [N-1:0] w_target_nxt;

`ifdef FIRE_RECALL_EN
    assign w_fire = i_fire_alert;
`else
    assign w_fire = 1'b0;
`endif

    // The first cycle after a fire recall ends restarts the scheduler from IDLE.
    assign w_state_eff = r_fire_q ? S_IDLE : r_state;

    assign w_sensor_onehot = (i_floor_sensor != '0) &&
                             ((i_floor_sensor & (i_floor_sensor - FLOOR0)) == '0);
    assign w_cur_nxt       = w_sensor_onehot ? i_floor_sensor : r_cur_floor;

    assign w_cur_below_mask = r_cur_floor - FLOOR0;
    assign w_cur_above_mask = ~(w_cur_below_mask | r_cur_floor);

    assign w_set_any  = r_pend_up | r_pend_down | r_pend_car |
                        i_button_up | i_button_down | i_button_select_floor;
    assign w_ahead_up = |(w_set_any & w_cur_above_mask);
    assign w_ahead_dn = |(w_set_any & w_cur_below_mask);

    // Opposite-direction hall calls are retired too when nothing remains ahead (turnaround).
    assign w_clr_car = i_serve_done ? r_cur_floor : '0;
    assign w_clr_up  = (i_serve_done && (w_state_eff != S_DOWN || !w_ahead_dn)) ? r_cur_floor : '0;
    assign w_clr_dn  = (i_serve_done && (w_state_eff != S_UP   || !w_ahead_up)) ? r_cur_floor : '0;

    // A button held through serve_done re-latches: set wins over clear.
    assign w_pend_up_nxt  = w_fire ? '0 : ((r_pend_up   & ~w_clr_up)  | i_button_up);
    assign w_pend_dn_nxt  = w_fire ? '0 : ((r_pend_down & ~w_clr_dn)  | i_button_down);
    assign w_pend_car_nxt = w_fire ? '0 : ((r_pend_car  & ~w_clr_car) | i_button_select_floor);

    assign w_any_nxt        = w_pend_up_nxt | w_pend_dn_nxt | w_pend_car_nxt;
    assign w_nxt_below_mask = w_cur_nxt - FLOOR0;
    assign w_nxt_above_mask = ~(w_nxt_below_mask | w_cur_nxt);
    assign w_above_calls    = w_any_nxt & w_nxt_above_mask;
    assign w_below_calls    = w_any_nxt & w_nxt_below_mask;
    assign w_above          = |w_above_calls;
    assign w_below          = |w_below_calls;
    assign w_here_car       = |(w_pend_car_nxt & w_cur_nxt);
    assign w_here_up        = |(w_pend_up_nxt  & w_cur_nxt);
    assign w_here_dn        = |(w_pend_dn_nxt  & w_cur_nxt);

    assign w_lowest_above = w_above_calls & (~w_above_calls + FLOOR0);

    always_comb begin
        w_highest_below = '0;
        for (int i = 0; i < N; i++) begin
            if (w_below_calls[i]) begin
                w_highest_below    = '0;
                w_highest_below[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state_eff;
        w_stop_nxt  = 1'b0;
        case (w_state_eff)
            S_IDLE: begin
                if (w_here_car || w_here_up || w_here_dn) begin
                    w_stop_nxt = 1'b1;
                end else if (w_above) begin
                    w_state_nxt = S_UP;
                end else if (w_below) begin
                    w_state_nxt = S_DOWN;
                end
            end
            S_UP: begin
                w_stop_nxt = w_here_car || w_here_up || (w_here_dn && !w_above);
                if (!w_above && !w_stop_nxt) begin
                    w_state_nxt = w_below ? S_DOWN : S_IDLE;
                end
            end
            S_DOWN: begin
                w_stop_nxt = w_here_car || w_here_dn || (w_here_up && !w_below);
                if (!w_below && !w_stop_nxt) begin
                    w_state_nxt = w_above ? S_UP : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_fire) begin
            w_state_nxt = (w_cur_nxt == FLOOR0) ? S_IDLE : S_DOWN;
            w_stop_nxt  = (w_cur_nxt == FLOOR0);
        end
    end

    always_comb begin
        w_target_nxt = '0;
        case (w_state_nxt)
            S_UP:    w_target_nxt = w_lowest_above;
            S_DOWN:  w_target_nxt = w_highest_below;
            default: w_target_nxt = w_stop_nxt ? w_cur_nxt : '0;
        endcase
        if (w_fire) begin
            w_target_nxt = FLOOR0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_cur_floor      <= FLOOR0;
            r_pend_up        <= '0;
            r_pend_down      <= '0;
            r_pend_car       <= '0;
            r_target_floor   <= '0;
            r_target_valid   <= 1'b0;
            r_direction_up   <= 1'b0;
            r_direction_down <= 1'b0;
            r_stop_here      <= 1'b0;
            r_fire_q         <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cur_floor      <= w_cur_nxt;
            r_pend_up        <= w_pend_up_nxt;
            r_pend_down      <= w_pend_dn_nxt;
            r_pend_car       <= w_pend_car_nxt;
            r_target_floor   <= w_target_nxt;
            r_target_valid   <= |w_target_nxt;
            r_direction_up   <= (w_state_nxt == S_UP);
            r_direction_down <= (w_state_nxt == S_DOWN);
            r_stop_here      <= w_stop_nxt;
            r_fire_q         <= w_fire;
        end
    end

    assign o_cur_floor      = r_cur_floor;
    assign o_pend_up        = r_pend_up;
    assign o_pend_down      = r_pend_down;
    assign o_pend_car       = r_pend_car;
    assign o_target_floor   = r_target_floor;
    assign o_target_valid   = r_target_valid;
    assign o_direction_up   = r_direction_up;
    assign o_direction_down = r_direction_down;
    assign o_stop_here      = r_stop_here;

endmodule
